mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters.
- Requester 0 is the memory_navigator-driven read path; requester 1 is a loader/processor read-write path.
- Round-robin arbitration, one access in flight at a time.
- Generates the RAM command signals and returns registered read data to the winning requester.

Parameters:
- ADDR_W, 32, address width of requesters and RAM port.
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in cycles from the address-sampling edge to valid mem_rdata. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- r0_req  in  1  requester 0 access request, level
- r0_we  in  1  requester 0 write enable (1 = write, 0 = read)
- r0_addr  in  ADDR_W  requester 0 address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_gnt  out  1  one-cycle grant pulse; command is on the RAM port this cycle
- r0_rvalid  out  1  one-cycle read-data-valid pulse
- r0_rdata  out  DATA_W  read data, valid while r0_rvalid=1
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_*, for requester 1
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, dominant over all else):
  - state = IDLE, rr_last = 1, cnt = 0.
  - All outputs 0: gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata, busy.
  - Reset mid-access aborts the access. A pending read produces no rvalid. A write whose ISSUE edge coincides with rst is suppressed (mem_we = 0 next cycle).
- Requester rules:
  - Hold req/we/addr/wdata stable from req assertion until the cycle gnt is seen.
  - May change or drop them from the following cycle.
  - Dropping req before gnt withdraws the request.
- FSM states:
  - IDLE: sample requests at the clock edge.
    - Neither requests: stay in IDLE.
    - One requests: it wins.
    - Both request: winner = requester != rr_last.
    - On a win: rr_last <= winner; mem_addr/mem_we/mem_wdata and winner gnt are registered from the winner's inputs; next state ISSUE.
  - ISSUE (exactly 1 cycle): winner gnt = 1; mem_we = captured we. RAM samples at the edge ending ISSUE. Next state DATA, with cnt loaded to RD_LAT for reads or 1 for writes.
  - DATA: gnt = 0, mem_we = 0. cnt decrements each cycle; leave when cnt reaches 1.
    - Read: at the edge ending the last DATA cycle, capture mem_rdata into the winner's rdata and set that rvalid.
    - Next state IDLE.
- Output timing:
  - rvalid is high for exactly the first IDLE cycle after a read.
  - rdata holds its value until the next read for that requester.
  - mem_addr and mem_wdata hold their last values outside ISSUE.
  - mem_we is high only during ISSUE of a write.
- Latency from req sampled in IDLE at edge E0:
  - gnt is high in the cycle after E0.
  - Read: rvalid is high RD_LAT+1 cycles after gnt.
  - Occupancy per access: write 2 cycles, read 1+RD_LAT cycles, plus the IDLE sampling cycle. IDLE arbitrates again in the same cycle rvalid is high.
- No starvation: under continuous requests from both sides, grants alternate strictly r0, r1, r0, …
- gnt and rvalid are never high for both requesters in the same cycle.
- busy = 1 in ISSUE and DATA.

Test Plan:
- Reset, then idle 5 cycles: all outputs 0, busy 0; rst asserted for 1 cycle clears everything on the next edge.
- r1 write addr=0x10, data=0xDEADBEEF, then r0 read addr=0x10 (RD_LAT=1): one-cycle r1_gnt with mem_we=1 and mem_addr=0x10; r0_gnt follows; r0_rvalid=1 with r0_rdata=0xDEADBEEF exactly 2 cycles after r0_gnt.
- Both req held high continuously with r0 reading addrs 0,1,2… and r1 writing: gnt order r0, r1, r0, r1; no gnt overlap; first tie after reset goes to r0.
- RD_LAT=3, r0 read: r0_rvalid exactly 4 cycles after r0_gnt; busy high for 4 cycles.
- rst asserted in the DATA cycle of a read: no rvalid at any later cycle, state IDLE, next request granted normally.
- r0 req pulsed then dropped before sampling (req low at the IDLE edge): no gnt, no mem_we, busy stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port synchronous RAM between two requesters.
// Requester 0 is the memory-navigator read path and requester 1 is the
// loader/processor read-write path. Arbitration is round-robin with a single
// access in flight. The RAM command and the read data returned to the
// winner are both registered.
//
// Handshake: a requester holds req/we/addr/wdata stable from the assertion
// of req until the cycle in which its gnt pulse is high. It may change or
// drop them from the next cycle on. Dropping req before gnt withdraws the
// request. For a read, rvalid pulses for one cycle RD_LAT+1 cycles after
// gnt, and rdata is valid in that cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   rN_req/we/addr/wdata     requester N command (N = 0, 1)
//   rN_gnt                   one-cycle grant; the command is on the RAM port
//   rN_rvalid/rdata          one-cycle read-data pulse and held read data
//   mem_addr/we/wdata        RAM command
//   mem_rdata                RAM read data, RD_LAT cycles after the address edge
//   busy                     high while an access occupies the port
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1     // legal range 1..7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t     state;
    logic       rr_last;   // requester that won most recently
    logic       win;       // requester owning the access in flight
    logic       win_we;    // access in flight is a write
    logic [2:0] cnt;       // DATA cycles remaining, including the current one
    logic       pick;      // winner if a request is sampled this cycle

    // A tie goes to the requester that did not win last time, which gives
    // strict alternation under continuous requests from both sides.
    always_comb begin
        pick = 1'b0;
        if (r0_req && r1_req) begin
            pick = ~rr_last;
        end else if (r1_req) begin
            pick = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            win       <= 1'b0;
            win_we    <= 1'b0;
            cnt       <= 3'd0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            // Pulses default low; they are set only on the edge that starts
            // the single cycle in which they are meant to be high.
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            mem_we    <= 1'b0;

            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        rr_last   <= pick;
                        win       <= pick;
                        win_we    <= pick ? r1_we : r0_we;
                        mem_addr  <= pick ? r1_addr : r0_addr;
                        mem_wdata <= pick ? r1_wdata : r0_wdata;
                        mem_we    <= pick ? r1_we : r0_we;
                        r0_gnt    <= ~pick;
                        r1_gnt    <= pick;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The RAM samples the command at the edge ending ISSUE.
                    cnt   <= win_we ? 3'd1 : 3'(RD_LAT);
                    state <= DATA;
                end

                DATA: begin
                    if (cnt == 3'd1) begin
                        state <= IDLE;
                        if (!win_we) begin
                            if (win) begin
                                r1_rdata  <= mem_rdata;
                                r1_rvalid <= 1'b1;
                            end else begin
                                r0_rdata  <= mem_rdata;
                                r0_rvalid <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
